// File: rtl/vga_sync_decoder_if.sv
// Sync/colour input bundle and recovered-timing output bundle of the VGA sync
// decoder. The timing source drives through master; the decoder sits on slave.
interface vga_sync_decoder_if;
  logic        pix_en;
  logic        hs;
  logic        vs;
  logic [11:0] colour_in;
  logic        pix_valid;
  logic        de;
  logic [10:0] x;
  logic [9:0]  y;
  logic [11:0] colour_out;
  logic        frame_start;
  logic        locked;
  logic        err;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;

  modport master (
    output pix_en, hs, vs, colour_in,
    input  pix_valid, de, x, y, colour_out, frame_start, locked, err, line_len, frame_lines
  );

  modport slave (
    input  pix_en, hs, vs, colour_in,
    output pix_valid, de, x, y, colour_out, frame_start, locked, err, line_len, frame_lines
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel coordinates, data-enable and colour from
// HS/VS/colour samples, measures line and frame lengths and tracks lock
// against the nominal timing. All sampling happens on clk edges with pix_en=1.
module vga_sync_decoder #(
  parameter int H_VISIBLE   = 800,
  parameter int H_BACK      = 64,
  parameter int H_TOTAL     = 1040,
  parameter int V_VISIBLE   = 600,
  parameter int V_BACK      = 23,
  parameter int V_TOTAL     = 666,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst,
  vga_sync_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [10:0] HPOS_MAX  = 11'h7FF;
  localparam logic [9:0]  VCNT_MAX  = 10'h3FF;
  localparam logic [10:0] H_BACK_W  = 11'(H_BACK);
  localparam logic [10:0] H_END_W   = 11'(H_BACK + H_VISIBLE);
  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [9:0]  V_BACK_W  = 10'(V_BACK);
  localparam logic [9:0]  V_END_W   = 10'(V_BACK + V_VISIBLE);
  localparam logic [9:0]  V_TOTAL_W = 10'(V_TOTAL);
  localparam logic [3:0]  LOCK_W    = 4'(LOCK_FRAMES);

  // Counters saturate instead of wrapping so a dead sync input cannot alias
  // back into a plausible position.
  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == HPOS_MAX) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == VCNT_MAX) ? v : v + 10'd1;
  endfunction

  // Sync history and position/measurement counters.
  logic        hs_q_r, vs_q_r;
  logic [10:0] hpos_r, line_cnt_r;
  logic [9:0]  vcnt_r, frame_cnt_r;
  state_t      state_r, state_nxt_s;
  logic [3:0]  good_cnt_r, good_cnt_nxt_s;
  logic        first_line_r, first_line_nxt_s;
  logic        frame_bad_r, frame_bad_nxt_s;
  logic        err_s;

  // Registered outputs.
  logic        pix_valid_r, de_r, frame_start_r, locked_r, err_r;
  logic [10:0] x_r, line_len_r;
  logic [9:0]  y_r, frame_lines_r;
  logic [11:0] colour_r;

  // Edge detection and next-value datapath.
  logic        hs_rise_s, hs_fall_s, vs_rise_s, vs_fall_s;
  logic [10:0] hpos_nxt_s, line_meas_s, line_cnt_nxt_s;
  logic [9:0]  vcnt_nxt_s, frame_meas_s, frame_cnt_nxt_s;
  logic        lost_sync_s, bad_line_s, frame_len_ok_s, visible_s, de_s;
  logic [3:0]  good_inc_s;

  assign hs_rise_s = bus.hs & ~hs_q_r;
  assign hs_fall_s = ~bus.hs & hs_q_r;
  assign vs_rise_s = bus.vs & ~vs_q_r;
  assign vs_fall_s = ~bus.vs & vs_q_r;

  assign hpos_nxt_s = hs_rise_s ? 11'd0 : sat_inc11(hpos_r);
  // A VS rise wins over a coincident HS rise: the line is not counted.
  assign vcnt_nxt_s = vs_rise_s ? 10'd0 : (hs_rise_s ? sat_inc10(vcnt_r) : vcnt_r);

  // line_cnt holds samples since the last HS fall minus one, so +1 is the length.
  assign line_meas_s     = sat_inc11(line_cnt_r);
  assign line_cnt_nxt_s  = hs_fall_s ? 11'd0 : line_meas_s;
  assign frame_meas_s    = hs_fall_s ? sat_inc10(frame_cnt_r) : frame_cnt_r;
  assign frame_cnt_nxt_s = vs_fall_s ? 10'd0 : frame_meas_s;

  // Only the transition into saturation is an event; staying saturated is not.
  assign lost_sync_s = ((hpos_nxt_s == HPOS_MAX) && (hpos_r != HPOS_MAX)) ||
                       ((vcnt_nxt_s == VCNT_MAX) && (vcnt_r != VCNT_MAX));
  assign bad_line_s  = (hs_fall_s && !first_line_r && (line_meas_s != H_TOTAL_W)) || lost_sync_s;
  assign frame_len_ok_s = (frame_meas_s == V_TOTAL_W);
  assign good_inc_s  = good_cnt_r + 4'd1;

  assign visible_s = (hpos_r >= H_BACK_W) && (hpos_r < H_END_W) &&
                     (vcnt_r >= V_BACK_W) && (vcnt_r < V_END_W);
  assign de_s      = visible_s && (state_r == ST_LOCKED);

  // Lock FSM next-state, frame qualification and error pulse generation.
  always_comb begin
    state_nxt_s      = state_r;
    good_cnt_nxt_s   = good_cnt_r;
    first_line_nxt_s = first_line_r;
    frame_bad_nxt_s  = frame_bad_r;
    err_s            = 1'b0;
    if (bus.pix_en) begin
      if (hs_fall_s) begin
        first_line_nxt_s = 1'b0;
      end else begin
        first_line_nxt_s = first_line_r;
      end
      case (state_r)
        ST_SEARCH: begin
          if (vs_fall_s) begin
            state_nxt_s      = ST_MEASURE;
            good_cnt_nxt_s   = 4'd0;
            first_line_nxt_s = 1'b1;
            frame_bad_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = ST_SEARCH;
          end
        end
        ST_MEASURE: begin
          if (vs_fall_s) begin
            frame_bad_nxt_s = 1'b0;
            if (frame_len_ok_s && !frame_bad_r && !bad_line_s) begin
              good_cnt_nxt_s = good_inc_s;
              if (good_inc_s >= LOCK_W) begin
                state_nxt_s = ST_LOCKED;
              end else begin
                state_nxt_s = ST_MEASURE;
              end
            end else begin
              good_cnt_nxt_s = 4'd0;
              err_s          = 1'b1;
            end
          end else if (bad_line_s) begin
            frame_bad_nxt_s = 1'b1;
          end else begin
            frame_bad_nxt_s = frame_bad_r;
          end
        end
        ST_LOCKED: begin
          if (bad_line_s || (vs_fall_s && !frame_len_ok_s)) begin
            state_nxt_s      = ST_SEARCH;
            good_cnt_nxt_s   = 4'd0;
            first_line_nxt_s = 1'b1;
            err_s            = 1'b1;
          end else begin
            state_nxt_s = ST_LOCKED;
          end
        end
        default: begin
          state_nxt_s      = ST_SEARCH;
          good_cnt_nxt_s   = 4'd0;
          first_line_nxt_s = 1'b1;
          frame_bad_nxt_s  = 1'b0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Sync history, counters and FSM state advance only on pixel samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q_r       <= 1'b1;
      vs_q_r       <= 1'b1;
      hpos_r       <= 11'd0;
      vcnt_r       <= 10'd0;
      line_cnt_r   <= 11'd0;
      frame_cnt_r  <= 10'd0;
      state_r      <= ST_SEARCH;
      good_cnt_r   <= 4'd0;
      first_line_r <= 1'b1;
      frame_bad_r  <= 1'b0;
    end else if (bus.pix_en) begin
      hs_q_r       <= bus.hs;
      vs_q_r       <= bus.vs;
      hpos_r       <= hpos_nxt_s;
      vcnt_r       <= vcnt_nxt_s;
      line_cnt_r   <= line_cnt_nxt_s;
      frame_cnt_r  <= frame_cnt_nxt_s;
      state_r      <= state_nxt_s;
      good_cnt_r   <= good_cnt_nxt_s;
      first_line_r <= first_line_nxt_s;
      frame_bad_r  <= frame_bad_nxt_s;
    end
  end

  // Output register: one clock after each sample; strobes drop between samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_valid_r   <= 1'b0;
      de_r          <= 1'b0;
      x_r           <= 11'd0;
      y_r           <= 10'd0;
      colour_r      <= 12'd0;
      frame_start_r <= 1'b0;
      locked_r      <= 1'b0;
      err_r         <= 1'b0;
      line_len_r    <= 11'd0;
      frame_lines_r <= 10'd0;
    end else if (bus.pix_en) begin
      pix_valid_r   <= 1'b1;
      de_r          <= de_s;
      x_r           <= de_s ? (hpos_r - H_BACK_W) : 11'd0;
      y_r           <= de_s ? (vcnt_r - V_BACK_W) : 10'd0;
      colour_r      <= de_s ? bus.colour_in : 12'd0;
      frame_start_r <= vs_rise_s;
      locked_r      <= (state_nxt_s == ST_LOCKED);
      err_r         <= err_s;
      line_len_r    <= hs_fall_s ? line_meas_s : line_len_r;
      frame_lines_r <= vs_fall_s ? frame_meas_s : frame_lines_r;
    end else begin
      pix_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      err_r         <= 1'b0;
    end
  end

  assign bus.pix_valid   = pix_valid_r;
  assign bus.de          = de_r;
  assign bus.x           = x_r;
  assign bus.y           = y_r;
  assign bus.colour_out  = colour_r;
  assign bus.frame_start = frame_start_r;
  assign bus.locked      = locked_r;
  assign bus.err         = err_r;
  assign bus.line_len    = line_len_r;
  assign bus.frame_lines = frame_lines_r;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a reduced timing (20x10 frame,
// 12x5 visible) so lock/relock sequences stay short. The driver pushes an
// expected record per pixel sample; a monitor pops it whenever pix_valid rises.
module tb_vga_sync_decoder;
  localparam int HV = 12, HB = 3, HT = 20;
  localparam int VV = 5, VB = 2, VT = 10;
  localparam int LF = 2;
  localparam int HS_W = 2, VS_W = 1;

  typedef struct packed {
    logic        de;
    logic [10:0] x;
    logic [9:0]  y;
    logic [11:0] col;
    logic        fs;
    logic        err;
    logic        lock;
    logic        chk_ctl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_sync_decoder_if bus ();

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_BACK(HB), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_BACK(VB), .V_TOTAL(VT), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   err_seen = 0;
  bit   cur_lock = 1'b0;
  int   short_line = -1;
  int   pause_line = -1, pause_p = -1;
  int   rst_line = -1, rst_p = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  function automatic logic [11:0] col_of(input int l, input int p);
    if (l == 2 && p == 6) return 12'hF00;
    if (l == 6 && p == 17) return 12'h00F;
    return 12'(l * 40 + p + 7);
  endfunction

  task automatic do_sample(input logic h, input logic v, input logic [11:0] c, input exp_t e);
    @(negedge clk);
    bus.hs = h;
    bus.vs = v;
    bus.colour_in = c;
    bus.pix_en = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.pix_en = 1'b0;
  endtask

  task automatic idle(input int n, input bit chk_ctl);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.chk_ctl = chk_ctl;
      e.lock = cur_lock;
      do_sample(1'b1, 1'b1, 12'hABC, e);
    end
  endtask

  task automatic pause_check(input exp_t e, input logic [10:0] hp);
    repeat (10) begin
      @(negedge clk);
      chk("pause_pix_valid", 64'(bus.pix_valid), 64'd0);
      chk("pause_hold", {bus.de, bus.x, bus.y, bus.colour_out}, {e.de, e.x, e.y, e.col});
      chk("pause_hpos", 64'(dut.hpos_r), 64'(hp));
    end
  endtask

  task automatic async_reset_check();
    #2 rst = 1'b0;
    #1;
    chk("async_reset_outputs",
        {bus.pix_valid, bus.de, bus.x, bus.y, bus.colour_out, bus.frame_start,
         bus.locked, bus.err, bus.line_len, bus.frame_lines}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cur_lock = 1'b0;
    exp_q.delete();
  endtask

  task automatic gen_frame(input bit lock_at_vs);
    exp_t e;
    int   len;
    bit   lock_after;
    bit   vis;
    for (int l = 0; l < VT; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        e = '0;
        e.chk_ctl = 1'b1;
        lock_after = cur_lock;
        if (l == 0 && p == 0) lock_after = lock_at_vs;
        if (short_line >= 0 && l == short_line + 1 && p == 0) begin
          lock_after = 1'b0;
          e.err = 1'b1;
        end
        vis = (p >= HS_W + 1 + HB) && (p < HS_W + 1 + HB + HV) &&
              (l >= VS_W - 1 + VB) && (l < VS_W - 1 + VB + VV);
        e.de = cur_lock && vis;
        if (e.de) begin
          e.x = 11'(p - HS_W - 1 - HB);
          e.y = 10'(l - VS_W + 1 - VB);
          e.col = col_of(l, p);
        end
        e.fs = (l == VS_W && p == 0);
        e.lock = lock_after;
        do_sample(logic'(p >= HS_W), logic'(l >= VS_W), col_of(l, p), e);
        cur_lock = lock_after;
        if (short_line >= 0 && l == short_line + 1 && p == 0)
          chk("short_line_len", 64'(bus.line_len), 64'(HT - 1));
        if (l == pause_line && p == pause_p) pause_check(e, 11'(p - HS_W));
        if (l == rst_line && p == rst_p) begin
          async_reset_check();
          return;
        end
      end
    end
  endtask

  // Monitor: pops one expected record per pix_valid strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.pix_valid === 1'b1) begin
        if (bus.err === 1'b1) err_seen++;
        if (exp_q.size() == 0) begin
          chk("spurious_pix_valid", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.chk_ctl)
            chk("sample", {bus.de, bus.x, bus.y, bus.colour_out, bus.frame_start, bus.err, bus.locked},
                {e.de, e.x, e.y, e.col, e.fs, e.err, e.lock});
          else
            chk("sample_nolock", {bus.de, bus.x, bus.y, bus.colour_out, bus.frame_start},
                {e.de, e.x, e.y, e.col, e.fs});
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Directed stimulus.
  initial begin
    bus.pix_en = 1'b0;
    bus.hs = 1'b1;
    bus.vs = 1'b1;
    bus.colour_in = 12'h000;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {bus.pix_valid, bus.de, bus.x, bus.y, bus.colour_out, bus.frame_start,
         bus.locked, bus.err, bus.line_len, bus.frame_lines}, 64'd0);
    rst = 1'b1;

    // Lock acquisition: VS fall plus LOCK_FRAMES good frames.
    idle(5, 1'b1);
    gen_frame(1'b0);
    gen_frame(1'b0);
    chk("not_locked_yet", 64'(bus.locked), 64'd0);
    gen_frame(1'b1);
    gen_frame(1'b1);
    chk("locked", 64'(bus.locked), 64'd1);
    chk("line_len", 64'(bus.line_len), 64'(HT));
    chk("frame_lines", 64'(bus.frame_lines), 64'(VT));

    // pix_en stall mid visible line.
    pause_line = 3;
    pause_p = 10;
    gen_frame(1'b1);
    pause_line = -1;

    // Short line while locked, then relock.
    short_line = 4;
    gen_frame(1'b1);
    short_line = -1;
    chk("unlocked_after_short", 64'(bus.locked), 64'd0);
    gen_frame(1'b0);
    gen_frame(1'b0);
    gen_frame(1'b1);
    gen_frame(1'b1);

    // HS stuck high: hpos saturates, one error, lock lost.
    err_seen = 0;
    idle(2100, 1'b0);
    cur_lock = 1'b0;
    @(negedge clk);
    chk("hold_err_pulses", 64'(err_seen), 64'd1);
    chk("hold_hpos_saturated", 64'(dut.hpos_r), 64'd2047);
    chk("hold_locked", 64'(bus.locked), 64'd0);
    gen_frame(1'b0);
    gen_frame(1'b0);
    gen_frame(1'b1);
    gen_frame(1'b1);

    // Asynchronous reset mid visible line, then relock.
    rst_line = 3;
    rst_p = 8;
    gen_frame(1'b1);
    rst_line = -1;
    idle(5, 1'b1);
    gen_frame(1'b0);
    gen_frame(1'b0);
    gen_frame(1'b1);
    gen_frame(1'b1);
    chk("relock_after_reset", 64'(bus.locked), 64'd1);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
